// File: rtl/write_combine_buffer.sv
// Single-line write-combining buffer: merges byte-enabled 32-bit stores into one
// 256-bit line and drains it as a masked line write. Optional idle self-drain under WCB_IDLE_FLUSH_EN.
module write_combine_buffer #(
  parameter int unsigned IDLE_LIMIT = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mem_write,
  input  logic [31:0]  mem_address,
  input  logic [31:0]  mem_wdata,
  input  logic [3:0]   mem_byte_enable,
  output logic         mem_resp,
  input  logic         flush,
  input  logic         rd_probe_valid,
  input  logic [31:0]  rd_probe_address,
  output logic         rd_stall,
  output logic         line_write,
  output logic [31:0]  line_address,
  output logic [255:0] line_wdata,
  output logic [31:0]  line_byte_mask,
  input  logic         line_resp,
  output logic         empty
);

  typedef enum logic [1:0] {EMPTY, FILL, DRAIN} state_t;

  state_t       state, state_next;
  logic [26:0]  tag;
  logic [31:0]  mask, mask_merged;
  logic [255:0] image, image_merged;
  logic [2:0]   word;
  logic         tag_hit;
  logic         idle_expire;
  logic         unused_low_bits;

  if (IDLE_LIMIT < 1 || IDLE_LIMIT > 255) begin : g_limit_check
    $error("write_combine_buffer: IDLE_LIMIT must be within 1..255");
  end

  assign word            = mem_address[4:2];
  assign tag_hit         = (mem_address[31:5] == tag);
  assign unused_low_bits = ^{mem_address[1:0], rd_probe_address[4:0]};

  // Buffered line image with the presented store overlaid on its enabled bytes.
  always_comb begin
    mask_merged  = mask;
    image_merged = image;
    for (int unsigned b = 0; b < 4; b++) begin
      if (mem_byte_enable[b]) begin
        mask_merged[{word, b[1:0]}]                = 1'b1;
        image_merged[{word, b[1:0], 3'b000} +: 8] = mem_wdata[{b[1:0], 3'b000} +: 8];
      end
    end
  end

`ifdef WCB_IDLE_FLUSH_EN
  logic [7:0] idle_cnt;

  always_ff @(posedge clk) begin
    if (rst || mem_resp || state_next != FILL) idle_cnt <= '0;
    else                                       idle_cnt <= idle_cnt + 8'd1;
  end

  assign idle_expire = (state == FILL) && !mem_resp && ((idle_cnt + 8'd1) == 8'(IDLE_LIMIT));
`else
  assign idle_expire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_next;
  end

  // A tag-hit store is merged before a same-cycle flush or idle expiry takes effect.
  always_comb begin
    state_next = state;
    case (state)
      EMPTY: if (mem_write && mem_byte_enable != '0) state_next = FILL;
      FILL: begin
        if (mem_write && !tag_hit)                   state_next = DRAIN;
        else if (mem_resp && mask_merged == '1)      state_next = DRAIN;
        else if (flush || idle_expire)               state_next = DRAIN;
      end
      DRAIN: if (line_resp) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  always_comb begin
    mem_resp = 1'b0;
    case (state)
      EMPTY:   mem_resp = mem_write;
      FILL:    mem_resp = mem_write & tag_hit;
      default: mem_resp = 1'b0;
    endcase
    line_write = (state == DRAIN);
    empty      = (state == EMPTY);
    rd_stall   = rd_probe_valid & (state != EMPTY) & (rd_probe_address[31:5] == tag);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag   <= '0;
      mask  <= '0;
      image <= '0;
    end else if (state == DRAIN) begin
      if (line_resp) begin
        mask  <= '0;
        image <= '0;
      end
    end else if (mem_resp && mem_byte_enable != '0) begin
      mask  <= mask_merged;
      image <= image_merged;
      if (state == EMPTY) tag <= mem_address[31:5];
    end
  end

  assign line_address   = {tag, 5'b0};
  assign line_wdata     = image;
  assign line_byte_mask = mask;

endmodule

// File: tb/tb_write_combine_buffer.sv
// Scoreboard bench for write_combine_buffer: a byte-map model predicts each drained line,
// a monitor compares every line_write against the queue of predictions.
module tb_write_combine_buffer;

  localparam int unsigned LIMIT = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         mem_write = 1'b0;
  logic [31:0]  mem_address = '0;
  logic [31:0]  mem_wdata = '0;
  logic [3:0]   mem_byte_enable = '0;
  logic         mem_resp;
  logic         flush = 1'b0;
  logic         rd_probe_valid = 1'b0;
  logic [31:0]  rd_probe_address = '0;
  logic         rd_stall;
  logic         line_write;
  logic [31:0]  line_address;
  logic [255:0] line_wdata;
  logic [31:0]  line_byte_mask;
  logic         line_resp = 1'b0;
  logic         empty;

  write_combine_buffer #(.IDLE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .mem_write(mem_write), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_byte_enable(mem_byte_enable), .mem_resp(mem_resp), .flush(flush),
    .rd_probe_valid(rd_probe_valid), .rd_probe_address(rd_probe_address), .rd_stall(rd_stall),
    .line_write(line_write), .line_address(line_address), .line_wdata(line_wdata),
    .line_byte_mask(line_byte_mask), .line_resp(line_resp), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]  addr;
    logic [255:0] data;
    logic [31:0]  mask;
  } line_t;

  line_t exp_q[$];
  int    tests = 0;
  int    fails = 0;

  // Reference model: a map of 32 bytes with per-byte valid flags.
  bit          m_valid = 1'b0;
  bit          m_draining = 1'b0;
  bit          auto_resp = 1'b0;
  logic [26:0] m_tag = '0;
  logic [26:0] drain_tag = '0;
  logic [7:0]  m_byte [32];
  bit          m_en [32];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_expected();
    line_t e;
    e.addr = {m_tag, 5'b0};
    e.data = '0;
    e.mask = '0;
    for (int i = 0; i < 32; i++) begin
      if (m_en[i]) begin
        e.data[8*i +: 8] = m_byte[i];
        e.mask[i]        = 1'b1;
      end
      m_en[i]   = 1'b0;
      m_byte[i] = '0;
    end
    exp_q.push_back(e);
    drain_tag  = m_tag;
    m_draining = 1'b1;
    m_valid    = 1'b0;
  endtask

  // Entered and left just after a rising edge.
  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                       input bit probe, input logic [31:0] pa);
    int unsigned waited = 0;
    bit miss, exp_stall, full;
    miss      = m_valid && (a[31:5] != m_tag);
    exp_stall = probe && ((m_valid && pa[31:5] == m_tag) || (m_draining && pa[31:5] == drain_tag));
    mem_write = 1'b1; mem_address = a; mem_wdata = d; mem_byte_enable = be;
    rd_probe_valid = probe; rd_probe_address = pa;
    if (miss) push_expected();
    @(negedge clk);
    if (probe) check("rd_stall", {255'b0, rd_stall}, {255'b0, exp_stall});
    if (miss) check("miss_resp", {255'b0, mem_resp}, '0);
    while (!mem_resp && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("store_accept", {255'b0, mem_resp}, 256'd1);
    full = 1'b0;
    if (mem_resp) begin
      if (!m_valid && be != 4'b0) begin
        m_valid = 1'b1;
        m_tag   = a[31:5];
      end
      if (m_valid) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) begin
            m_byte[int'(a[4:2]) * 4 + b] = d[8*b +: 8];
            m_en[int'(a[4:2]) * 4 + b]   = 1'b1;
          end
        end
        full = 1'b1;
        for (int i = 0; i < 32; i++) if (!m_en[i]) full = 1'b0;
        if (full) push_expected();
      end
    end
    @(posedge clk); #1;
    mem_write = 1'b0; mem_byte_enable = '0; rd_probe_valid = 1'b0;
    if (full) begin
      @(negedge clk);
      check("full_latency", {255'b0, line_write}, 256'd1);
      @(posedge clk); #1;
    end
  endtask

  task automatic do_flush();
    bit had;
    had   = m_valid;
    flush = 1'b1;
    if (had) push_expected();
    @(posedge clk); #1 flush = 1'b0;
    if (had) begin
      @(negedge clk);
      check("flush_latency", {255'b0, line_write}, 256'd1);
      @(posedge clk); #1;
    end
  endtask

  task automatic respond();
    line_resp = 1'b1;
    @(posedge clk); m_draining = 1'b0; #1 line_resp = 1'b0;
    @(negedge clk);
    check("empty_after_resp", {255'b0, empty}, 256'd1);
    check("line_write_fall", {255'b0, line_write}, '0);
    @(posedge clk); #1;
  endtask

  task automatic probe(input logic [31:0] pa, input bit exp, input string name);
    rd_probe_valid = 1'b1; rd_probe_address = pa;
    @(negedge clk);
    check(name, {255'b0, rd_stall}, {255'b0, exp});
    @(posedge clk); #1 rd_probe_valid = 1'b0;
  endtask

  // Monitor: each rising line_write must match the oldest prediction.
  initial begin
    line_t e;
    logic  lw_prev;
    lw_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (line_write && !lw_prev) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL sb_unexpected: got line_write for 0x%0h, expected none", line_address);
        end else begin
          e = exp_q.pop_front();
          check("sb_addr", {224'b0, line_address}, {224'b0, e.addr});
          check("sb_data", line_wdata, e.data);
          check("sb_mask", {224'b0, line_byte_mask}, {224'b0, e.mask});
        end
      end
      lw_prev = line_write;
    end
  end

  // Downstream responder with random latency.
  initial begin
    forever begin
      @(negedge clk);
      if (auto_resp && line_write) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        line_resp = 1'b1;
        @(posedge clk); m_draining = 1'b0; #1 line_resp = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] ev;
    logic [31:0]  bases [3];
    logic [31:0]  a, pa;
    logic [3:0]   be;
    bit           pr;
    bases = '{32'h4000_0000, 32'h4000_0020, 32'h7FFF_FFE0};
    for (int i = 0; i < 32; i++) begin m_byte[i] = '0; m_en[i] = 1'b0; end

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_line_write", {255'b0, line_write}, '0);
    check("rst_empty", {255'b0, empty}, 256'd1);
    check("rst_mem_resp", {255'b0, mem_resp}, '0);
    check("rst_rd_stall", {255'b0, rd_stall}, '0);
    check("rst_addr", {224'b0, line_address}, '0);
    check("rst_data", line_wdata, '0);
    check("rst_mask", {224'b0, line_byte_mask}, '0);
    @(posedge clk); #1 rst = 1'b0;

    // Partial store then flush
    store(32'h1000_0024, 32'hAABB_CCDD, 4'b0011, 1'b0, '0);
    do_flush();
    @(negedge clk);
    ev = '0; ev[47:32] = 16'hCCDD;
    check("partial_addr", {224'b0, line_address}, {224'b0, 32'h1000_0020});
    check("partial_mask", {224'b0, line_byte_mask}, {224'b0, 32'h0000_0030});
    check("partial_data", line_wdata, ev);
    @(posedge clk); #1;
    respond();

    // Full coalesce
    for (int i = 0; i < 8; i++)
      store(32'h2000_0000 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'hF, 1'b0, '0);
    @(negedge clk);
    check("full_mask", {224'b0, line_byte_mask}, {224'b0, 32'hFFFF_FFFF});
    for (int i = 0; i < 8; i++)
      check("full_lane", {224'b0, line_wdata[32*i +: 32]}, {224'b0, 32'hA000_0000 + 32'(i)});
    @(posedge clk); #1;
    respond();

    // Tag miss evicts, then the held store allocates the new tag
    auto_resp = 1'b1;
    store(32'h3000_0000, 32'h1234_5678, 4'hF, 1'b0, '0);
    store(32'h3000_0040, 32'h9ABC_DEF0, 4'hF, 1'b0, '0);
    probe(32'h3000_0044, 1'b1, "new_tag_stall");
    probe(32'h3000_0000, 1'b0, "old_tag_nostall");
    do_flush();

    // Overlapping stores and read stall
    store(32'h6000_0008, 32'h1122_3344, 4'b1100, 1'b0, '0);
    store(32'h6000_0008, 32'h5566_7788, 4'b0110, 1'b0, '0);
    rd_probe_valid = 1'b1; rd_probe_address = 32'h6000_0014;
    @(negedge clk);
    check("overlap_stall", {255'b0, rd_stall}, 256'd1);
    check("overlap_mask", {224'b0, line_byte_mask}, {224'b0, 32'h0000_0E00});
    check("overlap_word", {224'b0, line_wdata[95:64]}, {224'b0, 32'h1166_7700});
    @(posedge clk); #1;
    probe(32'h6000_0020, 1'b0, "other_line_stall");
    do_flush();

    // Idle behaviour
    store(32'h8000_0004, 32'hDEAD_BEEF, 4'hF, 1'b0, '0);
`ifdef WCB_IDLE_FLUSH_EN
    push_expected();
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 4) check("idle_before_limit", {255'b0, line_write}, '0);
      if (k == 5) check("idle_flush", {255'b0, line_write}, 256'd1);
    end
    @(posedge clk); #1;
`else
    repeat (40) @(negedge clk);
    check("idle_hold_lw", {255'b0, line_write}, '0);
    check("idle_hold_fill", {255'b0, empty}, '0);
    @(posedge clk); #1;
    do_flush();
`endif

    // Reset while draining
    store(32'h5000_0000, 32'h0BAD_F00D, 4'hF, 1'b0, '0);
    auto_resp = 1'b0;
    do_flush();
    rd_probe_valid = 1'b1; rd_probe_address = 32'h5000_0010;
    @(negedge clk);
    check("drain_stall", {255'b0, rd_stall}, 256'd1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    m_draining = 1'b0; m_valid = 1'b0;
    @(negedge clk);
    check("rst_drain_lw", {255'b0, line_write}, '0);
    check("rst_drain_empty", {255'b0, empty}, 256'd1);
    check("rst_drain_mask", {224'b0, line_byte_mask}, '0);
    check("rst_drain_stall", {255'b0, rd_stall}, '0);
    @(posedge clk); #1 line_resp = 1'b1; rd_probe_valid = 1'b0;
    @(posedge clk); #1 line_resp = 1'b0;
    @(negedge clk);
    check("late_resp_empty", {255'b0, empty}, 256'd1);
    check("late_resp_lw", {255'b0, line_write}, '0);
    @(posedge clk); #1;
    auto_resp = 1'b1;

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        do_flush();
      end else begin
        a  = bases[$urandom_range(0, 2)] + 32'($urandom_range(0, 7) * 4);
        be = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
        pr = 1'($urandom_range(0, 1));
        pa = bases[$urandom_range(0, 2)] + 32'($urandom_range(0, 31));
        store(a, $urandom, be, pr, pa);
      end
    end

    do_flush();
    for (int w = 0; w < 100 && !empty; w++) @(negedge clk);
    check("final_empty", {255'b0, empty}, 256'd1);
    check("scoreboard_empty", 256'(exp_q.size()), '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/write_combine_buffer.md
# write_combine_buffer

Single-line write-combining buffer between the CPU-side store port and the cache data-array write path. Collects 32-bit stores with byte enables into one 256-bit line image plus a 32-bit byte mask, then issues one masked line write downstream. The cache applies that line write with its byte-mask-to-bit-mask merge datapath. The block also stalls reads that hit the buffered line until that line has been drained.

## Interface
- IDLE_LIMIT, 16: idle cycles in FILL before the buffer self-drains (requires WCB_IDLE_FLUSH_EN); legal range 1..255.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_write  in  1  store request; held by requester until mem_resp.
- mem_address  in  32  byte address; [31:5] line tag, [4:2] word offset.
- mem_wdata  in  32  store data.
- mem_byte_enable  in  4  store byte enables.
- mem_resp  out  1  store accepted this cycle (combinational).
- flush  in  1  level; request drain of any buffered line.
- rd_probe_valid  in  1  a read is being presented to the cache.
- rd_probe_address  in  32  address of that read.
- rd_stall  out  1  read hits buffered line; cache must hold it (combinational).
- line_write  out  1  masked line write request to the data array.
- line_address  out  32  {tag, 5'b0}.
- line_wdata  out  256  buffered line image; unmasked bytes are 0.
- line_byte_mask  out  32  bit i set = byte i valid.
- line_resp  in  1  downstream write complete.
- empty  out  1  no line buffered (state EMPTY).

## Operation
- States: EMPTY, FILL, DRAIN. Reset → EMPTY, mask = 0, line image = 0, tag = 0, idle count = 0.
- Store placement: word w = mem_address[4:2]; data goes to bits [32w+:32]; enables go to mask bits [4w+:4]; a later store overwrites an earlier one only on the bytes it enables.
- EMPTY:
  - mem_write with nonzero enables: accept, latch tag, merge → FILL.
  - Enables == 0: accept, no allocation, stay EMPTY.
- FILL, mem_write with tag match: accept, merge, clear idle count.
  - If the resulting mask is 32'hFFFFFFFF → DRAIN.
- FILL, mem_write with tag miss: not accepted (mem_resp = 0) → DRAIN. The requester keeps holding the store; it is accepted in EMPTY after the drain.
- FILL with flush = 1 → DRAIN. A same-cycle tag-hit store is merged and accepted first.
- DRAIN:
  - line_write = 1; line_address, line_wdata and line_byte_mask are stable.
  - No store is accepted.
  - On line_resp: clear mask and line image → EMPTY.
- flush in EMPTY or DRAIN: no effect.
- rd_stall = rd_probe_valid & (state != EMPTY) & (rd_probe_address[31:5] == tag).
- Reset mid-DRAIN: drain abandoned, line_write deasserts next cycle, buffer content discarded.

## Timing
- All outputs reset to 0 except empty, which resets to 1.
- mem_resp is combinational in the cycle the store is sampled; merged state is visible the next cycle.
- Latency, first store to line_write via flush: accept at cycle N, flush at N+1, line_write high from N+2.
- Latency, full mask to line_write: 1 cycle after the accepting edge.
- line_write falls the cycle after line_resp is sampled. The earliest new accept is that same following cycle (state EMPTY).
- line_resp outside DRAIN is ignored.
- rd_stall is combinational with no added latency; it drops the cycle the state becomes EMPTY.

## Configuration
- WCB_IDLE_FLUSH_EN defined:
  - An 8-bit idle counter runs in FILL and increments on each cycle with no accepted store.
  - Reaching IDLE_LIMIT → DRAIN.
  - The counter clears on accept and on leaving FILL.
- Not defined: no counter; FILL exits only on full mask, tag miss or flush.

## Test plan
- Partial store then flush: store addr 0x1000_0024, data 0xAABBCCDD, enables 4'b0011, then flush. Required: line_write with line_address 0x1000_0020, line_byte_mask 32'h0000_0030, line_wdata[47:32] = 16'hCCDD, all other bits 0; line_resp → empty = 1.
- Full coalesce: eight stores to 0x2000_0000..0x2000_001C, all enables set. Required: line_write one cycle after the 8th accept, mask 32'hFFFFFFFF, each word in its lane.
- Tag miss: buffer holds 0x3000_0000, store to 0x3000_0040. Required: mem_resp = 0, drain of 0x3000_0000; after line_resp, the store is accepted with a new tag of 0x3000_0040.
- Overlap and read stall: two stores to the same word with enables 4'b1100 then 4'b0110. Required: mask nibble 4'b1110, middle bytes from the second store. A probe of the same line gives rd_stall = 1; a probe of another line gives 0.
- Idle flush (macro on, IDLE_LIMIT = 4): one store, then no activity. Required: line_write asserted 5 cycles after the accept. Macro off: the buffer stays in FILL indefinitely.
- Reset in DRAIN: rst while line_write = 1. Required: next cycle line_write = 0, empty = 1, mask 0; a later line_resp has no effect.
